// File: rtl/codec_sample_feeder.sv
// codec_sample_feeder: buffers stereo PCM from the player and hands one pair
// to the AC97 codec interface per codec frame.
// Counts FIFO underruns and keeps a sticky underrun flag.
// Optional build macro: CODEC_FEEDER_UNDERRUN_MUTE_EN. When it is defined, an
// underrun outputs silence. When it is undefined, the last sample repeats.
module codec_sample_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_left,
    input  logic [WIDTH-1:0]           in_right,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       playback_accept,
    output logic [WIDTH-1:0]           pcm_left,
    output logic [WIDTH-1:0]           pcm_right,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    output logic [CNT_W-1:0]           underrun_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_left  [DEPTH];
    logic [WIDTH-1:0] mem_right [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             accept_prev;
    logic [WIDTH-1:0] held_left;
    logic [WIDTH-1:0] held_right;
    logic             underrun_q;
    logic [CNT_W-1:0] count_q;

    logic             frame;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             starved;
    logic [WIDTH-1:0] under_left;
    logic [WIDTH-1:0] under_right;
    logic [WIDTH-1:0] next_left;
    logic [WIDTH-1:0] next_right;

    // A frame is the rising edge of the codec accept level. The codec derives its
    // own one-cycle pulse in the same way, so both sides agree on the cycle.
    assign frame      = playback_accept && !accept_prev;
    assign fifo_empty = (level_q == '0);
    assign in_ready   = (level_q != LVL_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = frame && !fifo_empty;
    assign starved    = frame && fifo_empty;

`ifdef CODEC_FEEDER_UNDERRUN_MUTE_EN
    assign under_left  = '0;
    assign under_right = '0;
`else
    assign under_left  = held_left;
    assign under_right = held_right;
`endif

    // The sample the codec takes in a frame is the FIFO head. If the FIFO is
    // empty, the underrun value is used instead. A push in this same cycle is
    // too late to fall through.
    always_comb begin
        next_left  = under_left;
        next_right = under_right;
        if (!fifo_empty) begin
            next_left  = mem_left[rd_ptr];
            next_right = mem_right[rd_ptr];
        end
    end

    // The codec sees the new sample in the frame cycle itself. Between frames,
    // the outputs stay at the value the codec latched.
    always_comb begin
        pcm_left  = held_left;
        pcm_right = held_right;
        if (frame) begin
            pcm_left  = next_left;
            pcm_right = next_right;
        end
    end

    assign level          = level_q;
    assign underrun       = underrun_q;
    assign underrun_count = count_q;

    // The sample storage needs no reset. Occupancy decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_left[wr_ptr]  <= in_left;
            mem_right[wr_ptr] <= in_right;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    // Occupancy moves by push minus pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // This block keeps the frame-edge history and the sample held for the codec.
    // It also tracks underruns: a sticky flag plus a saturating frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_prev <= 1'b0;
            held_left   <= '0;
            held_right  <= '0;
            underrun_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            accept_prev <= playback_accept;
            if (frame) begin
                held_left  <= next_left;
                held_right <= next_right;
            end
            if (starved) begin
                underrun_q <= 1'b1;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

endmodule
